// File: rtl/phy_rx_pkg.sv
// Shared symbols, lane FSM encoding and word-assembly helper for the multilane PHY receiver.
package phy_rx_pkg;

    localparam logic [7:0] COM_SYM_DEF = 8'hBC;
    localparam logic [7:0] IDL_SYM_DEF = 8'h7C;
    localparam int         WORD_BYTES  = 4;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        LOCKING = 2'd1,
        LOCKED  = 2'd2
    } lane_state_t;

    // Byte position 0 is the MSB of the word.
    function automatic logic [31:0] put_byte(input logic [31:0] word,
                                             input logic [1:0]  pos,
                                             input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        case (pos)
            2'd0:    w[31:24] = b;
            2'd1:    w[23:16] = b;
            2'd2:    w[15:8]  = b;
            default: w[7:0]   = b;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/phy_rx_lane_align.sv
// Per-lane COM alignment: shift register, bit counter, lock FSM and byte strobe.
//   state   | meaning
//   SEARCH  | sliding bit-by-bit for a COM symbol
//   LOCKING | byte boundary guessed, counting consecutive COMs
//   LOCKED  | aligned; one byte strobe every 8 bits, held until reset
module phy_rx_lane_align
    import phy_rx_pkg::*;
#(
    parameter logic [7:0] COM_SYM   = COM_SYM_DEF,
    parameter int         COM_COUNT = 4
) (
    input  logic       clk_32f,
    input  logic       reset,
    input  logic       i_data,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_locked
);

    localparam logic [3:0] LP_LOCK_CNT = 4'(COM_COUNT);

    lane_state_t r_state;
    lane_state_t w_state_next;
    logic [6:0]  r_sr_hist;
    logic [2:0]  r_bit_cnt;
    logic [3:0]  r_com_cnt;
    logic [7:0]  r_byte;
    logic        r_byte_valid;
    logic [7:0]  w_sr_next;
    logic        w_byte_end;
    logic        w_is_com;

    // Only seven history bits are needed; the eighth is the incoming bit.
    assign w_sr_next  = {r_sr_hist, i_data};
    assign w_byte_end = (r_bit_cnt == 3'd7);
    assign w_is_com   = (w_sr_next == COM_SYM);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SEARCH: begin
                if (w_is_com) begin
                    w_state_next = LOCKING;
                end
            end
            LOCKING: begin
                if (w_byte_end) begin
                    if (!w_is_com) begin
                        w_state_next = SEARCH;
                    end else if ((r_com_cnt + 4'd1) == LP_LOCK_CNT) begin
                        w_state_next = LOCKED;
                    end
                end
            end
            LOCKED:  w_state_next = LOCKED;
            default: w_state_next = SEARCH;
        endcase
    end

    always_comb begin
        o_locked = (r_state == LOCKED);
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_sr_hist    <= 7'd0;
            r_bit_cnt    <= 3'd0;
            r_com_cnt    <= 4'd0;
            r_byte       <= 8'd0;
            r_byte_valid <= 1'b0;
        end else begin
            r_sr_hist    <= w_sr_next[6:0];
            r_byte_valid <= 1'b0;
            case (r_state)
                SEARCH: begin
                    r_bit_cnt <= 3'd0;
                    r_com_cnt <= w_is_com ? 4'd1 : 4'd0;
                end
                LOCKING: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_byte_end) begin
                        r_com_cnt <= w_is_com ? (r_com_cnt + 4'd1) : 4'd0;
                    end
                end
                LOCKED: begin
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (w_byte_end) begin
                        r_byte       <= w_sr_next;
                        r_byte_valid <= 1'b1;
                    end
                end
                default: begin
                    r_bit_cnt <= 3'd0;
                    r_com_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign o_byte       = r_byte;
    assign o_byte_valid = r_byte_valid;

endmodule

// File: rtl/phy_rx_multilane.sv
// Multilane PHY receiver: per-lane alignment, lock aggregation and round-robin un-striping into 32-bit words.
// Define PHY_RX_ERR_CNT_EN to add the saturating err_count port for mixed-symbol and skew slots.
module phy_rx_multilane
    import phy_rx_pkg::*;
#(
    parameter int         NUM_LANES = 2,
    parameter logic [7:0] COM_SYM   = COM_SYM_DEF,
    parameter logic [7:0] IDL_SYM   = IDL_SYM_DEF,
    parameter int         COM_COUNT = 4
) (
    input  logic                 clk_32f,
    input  logic                 reset,
    input  logic [NUM_LANES-1:0] data_in,
    output logic [31:0]          data_out,
    output logic                 valid_out,
    output logic                 active_out,
    output logic [NUM_LANES-1:0] lane_locked
`ifdef PHY_RX_ERR_CNT_EN
    ,
    output logic [7:0]           err_count
`endif
);

    localparam logic [2:0] LP_STEP = 3'(NUM_LANES);
    localparam logic [2:0] LP_WORD = 3'(WORD_BYTES);

    logic [NUM_LANES-1:0] w_bv;
    logic [NUM_LANES-1:0] w_locked;
    logic [7:0]           w_lane_byte [NUM_LANES];
    logic [31:0]          w_word_next;
    logic [2:0]           w_idx_next;
    logic                 w_slot;
    logic                 w_skew;
    logic                 w_all_ctrl;
    logic                 w_any_ctrl;

    logic [NUM_LANES-1:0] r_lane_locked;
    logic                 r_active;
    logic [31:0]          r_word;
    logic [2:0]           r_idx;
    logic                 r_pend;
    logic [31:0]          r_pend_word;
    logic [31:0]          r_data_out;
    logic                 r_valid_out;

    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
        phy_rx_lane_align #(
            .COM_SYM   (COM_SYM),
            .COM_COUNT (COM_COUNT)
        ) u_lane (
            .clk_32f      (clk_32f),
            .reset        (reset),
            .i_data       (data_in[gi]),
            .o_byte       (w_lane_byte[gi]),
            .o_byte_valid (w_bv[gi]),
            .o_locked     (w_locked[gi])
        );
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_lane_locked <= '0;
            r_active      <= 1'b0;
        end else begin
            r_lane_locked <= w_locked;
            r_active      <= &w_locked;
        end
    end

    always_comb begin
        w_all_ctrl  = 1'b1;
        w_any_ctrl  = 1'b0;
        w_word_next = r_word;
        for (int i = 0; i < NUM_LANES; i++) begin
            if ((w_lane_byte[i] == IDL_SYM) || (w_lane_byte[i] == COM_SYM)) begin
                w_any_ctrl = 1'b1;
            end else begin
                w_all_ctrl = 1'b0;
            end
            w_word_next = put_byte(w_word_next, r_idx[1:0] + 2'(i), w_lane_byte[i]);
        end
    end

    assign w_slot     = r_active && (|w_bv);
    assign w_skew     = w_slot && !(&w_bv);
    assign w_idx_next = r_idx + LP_STEP;

    // Any slot carrying control symbols (all or some lanes) or skew restarts the word.
    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_word      <= 32'd0;
            r_idx       <= 3'd0;
            r_pend      <= 1'b0;
            r_pend_word <= 32'd0;
        end else begin
            r_pend <= 1'b0;
            if (w_slot) begin
                if (w_skew || w_any_ctrl) begin
                    r_word <= 32'd0;
                    r_idx  <= 3'd0;
                end else if (w_idx_next == LP_WORD) begin
                    r_pend      <= 1'b1;
                    r_pend_word <= w_word_next;
                    r_word      <= 32'd0;
                    r_idx       <= 3'd0;
                end else begin
                    r_word <= w_word_next;
                    r_idx  <= w_idx_next;
                end
            end
        end
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_data_out  <= 32'd0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= r_pend;
            if (r_pend) begin
                r_data_out <= r_pend_word;
            end
        end
    end

    assign data_out    = r_data_out;
    assign valid_out   = r_valid_out;
    assign active_out  = r_active;
    assign lane_locked = r_lane_locked;

`ifdef PHY_RX_ERR_CNT_EN
    logic       w_err;
    logic [7:0] r_err_count;

    assign w_err = w_skew || (w_slot && w_any_ctrl && !w_all_ctrl);

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            r_err_count <= 8'd0;
        end else if (w_err && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'd1;
        end
    end

    assign err_count = r_err_count;
`endif

endmodule

// File: tb/tb_phy_rx_multilane.sv
// Bench for phy_rx_multilane: directed lock/reset scenarios plus random byte slots against a byte-level word model.
`timescale 1ns/1ps
module tb_phy_rx_multilane;

    localparam int         NL  = 2;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;

    logic          clk_32f = 1'b0;
    logic          reset   = 1'b0;
    logic [NL-1:0] data_in = '0;
    logic [31:0]   data_out;
    logic          valid_out;
    logic          active_out;
    logic [NL-1:0] lane_locked;
`ifdef PHY_RX_ERR_CNT_EN
    logic [7:0]    err_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit model_on = 1'b0;
    int exp_err  = 0;
    logic [7:0]  exp_part [$];
    logic [31:0] exp_q    [$];
    logic [31:0] obs_q    [$];

    phy_rx_multilane #(
        .NUM_LANES (NL),
        .COM_SYM   (COM),
        .IDL_SYM   (IDL),
        .COM_COUNT (4)
    ) dut (
        .clk_32f     (clk_32f),
        .reset       (reset),
        .data_in     (data_in),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .active_out  (active_out),
        .lane_locked (lane_locked)
`ifdef PHY_RX_ERR_CNT_EN
        , .err_count (err_count)
`endif
    );

    always #5 clk_32f = ~clk_32f;

    always @(negedge clk_32f) begin
        if (valid_out === 1'b1) obs_q.push_back(data_out);
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1);
    end

    // lane 0 byte in the low bits
    function automatic logic [8*NL-1:0] mk(input logic [7:0] b0, input logic [7:0] b1);
        return {b1, b0};
    endfunction

    function automatic logic [7:0] rand_data();
        logic [7:0] b;
        do b = 8'($urandom_range(0, 255)); while (b == COM || b == IDL);
        return b;
    endfunction

    // Word model: data bytes queue in lane order; any control symbol in a slot empties the queue.
    task automatic model_slot(input logic [8*NL-1:0] s);
        int n_ctrl = 0;
        for (int i = 0; i < NL; i++)
            if (s[8*i +: 8] == COM || s[8*i +: 8] == IDL) n_ctrl++;
        if (n_ctrl == NL) begin
            exp_part.delete();
        end else if (n_ctrl > 0) begin
            exp_part.delete();
            exp_err++;
        end else begin
            for (int i = 0; i < NL; i++) exp_part.push_back(s[8*i +: 8]);
            if (exp_part.size() == 4) begin
                exp_q.push_back({exp_part[0], exp_part[1], exp_part[2], exp_part[3]});
                exp_part.delete();
            end
        end
    endtask

    task automatic send_slot(input logic [8*NL-1:0] s);
        for (int k = 7; k >= 0; k--) begin
            for (int i = 0; i < NL; i++) data_in[i] = s[8*i + k];
            @(posedge clk_32f); #1;
        end
        if (model_on) model_slot(s);
    endtask

    task automatic apply_reset();
        reset    = 1'b0;
        data_in  = '0;
        model_on = 1'b0;
        repeat (3) @(posedge clk_32f);
        #1;
        exp_part.delete();
        exp_q.delete();
        obs_q.delete();
        exp_err = 0;
        reset   = 1'b1;
    endtask

    task automatic lock_all();
        repeat (4) send_slot(mk(COM, COM));
        send_slot(mk(IDL, IDL));
        model_on = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        reset = 1'b0;
        #1;
        n_checks++; if (data_out !== 32'd0) $display("FAIL reset_data_out: got %h expected 00000000", data_out); else n_pass++;
        n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid_out); else n_pass++;
        n_checks++; if (active_out !== 1'b0) $display("FAIL reset_active: got %b expected 0", active_out); else n_pass++;
        n_checks++; if (lane_locked !== 2'b00) $display("FAIL reset_locked: got %b expected 00", lane_locked); else n_pass++;
`ifdef PHY_RX_ERR_CNT_EN
        n_checks++; if (err_count !== 8'd0) $display("FAIL reset_err_count: got %0d expected 0", err_count); else n_pass++;
`endif
        reset = 1'b1;
    endtask

    task automatic test_lock();
        repeat (4) send_slot(mk(COM, COM));
        n_checks++; if (lane_locked !== 2'b00) $display("FAIL lock_early: got %b expected 00", lane_locked); else n_pass++;
        for (int k = 7; k >= 0; k--) begin
            for (int i = 0; i < NL; i++) data_in[i] = IDL[k];
            @(posedge clk_32f); #1;
            if (k == 7) begin
                n_checks++; if (lane_locked !== 2'b11) $display("FAIL lock_lanes: got %b expected 11", lane_locked); else n_pass++;
                n_checks++; if (active_out !== 1'b1) $display("FAIL lock_active: got %b expected 1", active_out); else n_pass++;
            end
        end
        n_checks++; if (obs_q.size() != 0) $display("FAIL lock_no_valid: got %0d words expected 0", obs_q.size()); else n_pass++;
        model_on = 1'b1;
    endtask

    task automatic test_basic_word();
        logic [31:0] o, e;
        send_slot(mk(8'hAA, 8'hBB));
        send_slot(mk(8'hCC, 8'hDD));
        for (int k = 7; k >= 0; k--) begin
            for (int i = 0; i < NL; i++) data_in[i] = IDL[k];
            @(posedge clk_32f); #1;
            if (k == 7) begin
                n_checks++; if (valid_out !== 1'b0) $display("FAIL basic_latency_early: got %b expected 0", valid_out); else n_pass++;
            end
            if (k == 6) begin
                n_checks++; if (valid_out !== 1'b1) $display("FAIL basic_latency_valid: got %b expected 1", valid_out); else n_pass++;
                n_checks++; if (data_out !== 32'hAABBCCDD) $display("FAIL basic_data: got %h expected aabbccdd", data_out); else n_pass++;
            end
        end
        model_slot(mk(IDL, IDL));
        n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL basic_count: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL basic_model: got %h expected %h", o, e); else n_pass++;
        end
    endtask

    task automatic test_idle_split();
        send_slot(mk(IDL, IDL));
        send_slot(mk(COM, IDL));
        send_slot(mk(8'hAA, 8'hBB));
        send_slot(mk(IDL, IDL));
        send_slot(mk(8'hCC, 8'hDD));
        send_slot(mk(IDL, COM));
        send_slot(mk(IDL, IDL));
        n_checks++; if (obs_q.size() != 0) $display("FAIL split_no_word: got %0d words expected 0", obs_q.size()); else n_pass++;
        n_checks++; if (exp_q.size() != obs_q.size()) $display("FAIL split_model: got %0d expected %0d", obs_q.size(), exp_q.size()); else n_pass++;
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_mixed();
`ifdef PHY_RX_ERR_CNT_EN
        n_checks++; if (err_count !== 8'd0) $display("FAIL mixed_err_before: got %0d expected 0", err_count); else n_pass++;
`endif
        send_slot(mk(8'hAA, 8'hBB));
        send_slot(mk(IDL, 8'hBB));
        send_slot(mk(8'hCC, 8'hDD));
        send_slot(mk(8'hEE, 8'hFF));
        send_slot(mk(IDL, IDL));
        n_checks++; if (obs_q.size() != 1) $display("FAIL mixed_count: got %0d expected 1", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0] !== 32'hCCDDEEFF) $display("FAIL mixed_word: got %h expected ccddeeff", obs_q[0]); else n_pass++;
        end
`ifdef PHY_RX_ERR_CNT_EN
        n_checks++; if (err_count !== 8'd1) $display("FAIL mixed_err_after: got %0d expected 1", err_count); else n_pass++;
`endif
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        logic [7:0]  b [NL];
        logic [31:0] o, e;
        int kind, words;
        for (int n = 0; n < 60; n++) begin
            kind = $urandom_range(0, 9);
            for (int i = 0; i < NL; i++) b[i] = rand_data();
            if (kind == 0) begin
                for (int i = 0; i < NL; i++) b[i] = ($urandom_range(0, 1) != 0) ? COM : IDL;
            end else if (kind == 1) begin
                b[$urandom_range(0, NL-1)] = ($urandom_range(0, 1) != 0) ? COM : IDL;
            end
            send_slot(mk(b[0], b[1]));
        end
        send_slot(mk(IDL, IDL));
        words = exp_q.size();
        n_checks++; if (obs_q.size() != words) $display("FAIL random_count: got %0d expected %0d", obs_q.size(), words); else n_pass++;
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            o = obs_q.pop_front(); e = exp_q.pop_front();
            n_checks++; if (o !== e) $display("FAIL random_word: got %h expected %h", o, e); else n_pass++;
        end
`ifdef PHY_RX_ERR_CNT_EN
        n_checks++; if (err_count !== 8'(exp_err)) $display("FAIL random_err_count: got %0d expected %0d", err_count, exp_err); else n_pass++;
`endif
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_partial_lock();
        apply_reset();
        repeat (3) send_slot(mk(COM, COM));
        send_slot(mk(COM, 8'h00));
        send_slot(mk(8'hAA, 8'h00));
        n_checks++; if (lane_locked !== 2'b01) $display("FAIL partial_locked: got %b expected 01", lane_locked); else n_pass++;
        n_checks++; if (active_out !== 1'b0) $display("FAIL partial_active: got %b expected 0", active_out); else n_pass++;
        send_slot(mk(8'hCC, 8'h00));
        send_slot(mk(8'h11, 8'h00));
        send_slot(mk(8'h22, 8'h00));
        n_checks++; if (active_out !== 1'b0) $display("FAIL partial_active_hold: got %b expected 0", active_out); else n_pass++;
        n_checks++; if (obs_q.size() != 0) $display("FAIL partial_ignored: got %0d words expected 0", obs_q.size()); else n_pass++;
        lock_all();
        n_checks++; if (active_out !== 1'b1) $display("FAIL partial_relock: got %b expected 1", active_out); else n_pass++;
        send_slot(mk(8'h12, 8'h34));
        send_slot(mk(8'h56, 8'h78));
        send_slot(mk(IDL, IDL));
        n_checks++; if (obs_q.size() != 1) $display("FAIL partial_count: got %0d expected 1", obs_q.size()); else n_pass++;
        if (obs_q.size() > 0) begin
            n_checks++; if (obs_q[0] !== 32'h12345678) $display("FAIL partial_word: got %h expected 12345678", obs_q[0]); else n_pass++;
        end
        obs_q.delete(); exp_q.delete();
    endtask

    task automatic test_reset_midword();
        logic [8*NL-1:0] s;
        send_slot(mk(8'hAA, 8'hBB));
        s = mk(8'hCC, 8'hDD);
        for (int k = 7; k >= 4; k--) begin
            for (int i = 0; i < NL; i++) data_in[i] = s[8*i + k];
            @(posedge clk_32f); #1;
        end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (data_out !== 32'd0) $display("FAIL midrst_data: got %h expected 00000000", data_out); else n_pass++;
        n_checks++; if (valid_out !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", valid_out); else n_pass++;
        n_checks++; if (lane_locked !== 2'b00) $display("FAIL midrst_locked: got %b expected 00", lane_locked); else n_pass++;
        n_checks++; if (active_out !== 1'b0) $display("FAIL midrst_active: got %b expected 0", active_out); else n_pass++;
        apply_reset();
        lock_all();
        send_slot(mk(8'h11, 8'h22));
        send_slot(mk(8'h33, 8'h44));
        send_slot(mk(IDL, IDL));
        n_checks++; if (data_out !== 32'h11223344) $display("FAIL midrst_word: got %h expected 11223344", data_out); else n_pass++;
        n_checks++; if (obs_q.size() != 1) $display("FAIL midrst_count: got %0d expected 1", obs_q.size()); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_basic_word();
        test_idle_split();
        test_mixed();
        test_random();
        test_partial_lock();
        test_reset_midword();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
